// File: rtl/ysyx_22050133_mdu.sv
// ----------------------------------------------------------------------------
// ysyx_22050133_mdu
//   Iterative RV64M multiply/divide unit with a valid/ready handshake.
//   Multiplication is shift-add on operand magnitudes (MUL_BPC multiplier bits
//   per cycle) with a sign fix-up; division is restoring, one quotient bit per
//   cycle, also on magnitudes. Divide-by-zero, signed overflow and illegal
//   word-MULH* requests finish in one cycle without iterating.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             abort any in-flight op, ignore in_valid this cycle
//   in_valid/in_ready request handshake (in_ready only while idle, not in reset)
//   op, word          operation (MUL..REMU) and 32-bit W-variant select
//   src1, src2        rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//   out_valid/out_ready result handshake; result held while unacknowledged
//   result            XLEN-bit result
//   busy              unit is not idle
// ----------------------------------------------------------------------------
module ysyx_22050133_mdu #(
  parameter int XLEN    = 64,
  parameter int MUL_BPC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int PW  = 2 * XLEN;
  localparam int CW  = $clog2(XLEN + 1);
  localparam int WSH = XLEN - 32;

  // Iteration counts for the four (op class, width) combinations
  localparam logic [CW-1:0] N_MUL_D = CW'(XLEN / MUL_BPC);
  localparam logic [CW-1:0] N_MUL_W = CW'(32 / MUL_BPC);
  localparam logic [CW-1:0] N_DIV_D = CW'(XLEN);
  localparam logic [CW-1:0] N_DIV_W = CW'(32);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Sign-extend a 32-bit word result to XLEN
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  state_t            state_r;
  logic [2:0]        op_r;
  logic              word_r;
  logic              neg_a_r;    // product / quotient must be negated
  logic              neg_b_r;    // remainder must be negated
  logic              spec_r;     // acc_r holds a ready-made special result
  logic [CW-1:0]     cnt_r;
  logic [PW-1:0]     a_r;        // multiplicand (shifted left) or divisor
  logic [XLEN-1:0]   b_r;        // multiplier (shifted right) or dividend/quotient
  logic [PW-1:0]     acc_r;      // product accumulator or partial remainder
  logic              out_valid_r;
  logic [XLEN-1:0]   result_r;

  logic              accept_s;
  logic              sgn1_s, sgn2_s;
  logic [XLEN-1:0]   v1_s, v2_s, mag1_s, mag2_s, dvd_s;
  logic              neg1_s, neg2_s;
  logic              illegal_s, div_zero_s, ovf_s, spec_s;
  logic [XLEN-1:0]   spec_val_s;

  logic [PW-1:0]     pp_s;
  logic [XLEN:0]     sh_s, rem_s;
  logic              qbit_s;
  logic [PW-1:0]     prod_s;
  logic [XLEN-1:0]   quo_s, rem_mag_s, rem_fix_s;
  logic [XLEN-1:0]   final_s;

  assign in_ready  = (state_r == S_IDLE) && !rst;
  assign accept_s  = in_valid && in_ready && !flush;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign busy      = (state_r != S_IDLE);

  // Decode the request: operand views, magnitudes and one-cycle special cases
  always_comb begin
    sgn1_s = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sgn2_s = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    if (word) begin
      v1_s = sgn1_s ? sext32(src1[31:0]) : {{(XLEN-32){1'b0}}, src1[31:0]};
      v2_s = sgn2_s ? sext32(src2[31:0]) : {{(XLEN-32){1'b0}}, src2[31:0]};
      dvd_s = sext32(src1[31:0]);
    end else begin
      v1_s = src1;
      v2_s = src2;
      dvd_s = src1;
    end
    neg1_s = sgn1_s && v1_s[XLEN-1];
    neg2_s = sgn2_s && v2_s[XLEN-1];
    mag1_s = neg1_s ? -v1_s : v1_s;
    mag2_s = neg2_s ? -v2_s : v2_s;

    illegal_s  = word && !op[2] && (op[1:0] != 2'd0);
    div_zero_s = op[2] && (v2_s == {XLEN{1'b0}});
    // Only DIV/REM (op[0]==0) are signed divisions that can overflow
    ovf_s = op[2] && !op[0] && (v2_s == {XLEN{1'b1}}) &&
            (word ? (src1[31:0] == 32'h8000_0000)
                  : (src1 == {1'b1, {(XLEN-1){1'b0}}}));
    spec_s = illegal_s || div_zero_s || ovf_s;

    if (illegal_s) begin
      spec_val_s = {XLEN{1'b0}};
    end else if (div_zero_s) begin
      spec_val_s = op[1] ? dvd_s : {XLEN{1'b1}};
    end else if (ovf_s) begin
      spec_val_s = op[1] ? {XLEN{1'b0}} : dvd_s;
    end else begin
      spec_val_s = {XLEN{1'b0}};
    end
  end

  // One iteration step: MUL_BPC shift-add bits or one restoring-division bit
  always_comb begin
    pp_s = {PW{1'b0}};
    for (int i = 0; i < MUL_BPC; i++) begin
      pp_s = pp_s + ({PW{b_r[i]}} & (a_r << i));
    end
    sh_s = {acc_r[XLEN-1:0], b_r[XLEN-1]};
    if (sh_s >= {1'b0, a_r[XLEN-1:0]}) begin
      rem_s  = sh_s - {1'b0, a_r[XLEN-1:0]};
      qbit_s = 1'b1;
    end else begin
      rem_s  = sh_s;
      qbit_s = 1'b0;
    end
  end

  // Sign fix-up and result selection once the iteration has finished
  always_comb begin
    prod_s    = neg_a_r ? -acc_r : acc_r;
    quo_s     = neg_a_r ? -b_r : b_r;
    rem_mag_s = acc_r[XLEN-1:0];
    rem_fix_s = neg_b_r ? -rem_mag_s : rem_mag_s;
    if (spec_r) begin
      final_s = acc_r[XLEN-1:0];
    end else begin
      case (op_r)
        3'd0:                final_s = word_r ? sext32(prod_s[31:0]) : prod_s[XLEN-1:0];
        3'd1, 3'd2, 3'd3:    final_s = prod_s[PW-1:XLEN];
        3'd4, 3'd5:          final_s = word_r ? sext32(quo_s[31:0]) : quo_s;
        3'd6, 3'd7:          final_s = word_r ? sext32(rem_fix_s[31:0]) : rem_fix_s;
        default:             final_s = {XLEN{1'b0}};
      endcase
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      op_r        <= 3'd0;
      word_r      <= 1'b0;
      neg_a_r     <= 1'b0;
      neg_b_r     <= 1'b0;
      spec_r      <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      a_r         <= {PW{1'b0}};
      b_r         <= {XLEN{1'b0}};
      acc_r       <= {PW{1'b0}};
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
    end else if (flush) begin
      // Drop whatever is in flight; the last result value stays visible
      state_r     <= S_IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            op_r    <= op;
            word_r  <= word;
            neg_a_r <= neg1_s ^ neg2_s;
            neg_b_r <= neg1_s;
            if (spec_s) begin
              spec_r  <= 1'b1;
              acc_r   <= {{(PW-XLEN){1'b0}}, spec_val_s};
              state_r <= S_DONE;
            end else begin
              spec_r  <= 1'b0;
              acc_r   <= {PW{1'b0}};
              state_r <= S_CALC;
              if (op[2]) begin
                // Dividend is left-aligned so its MSB is shifted out first
                a_r   <= {{(PW-XLEN){1'b0}}, mag2_s};
                b_r   <= word ? (mag1_s << WSH) : mag1_s;
                cnt_r <= word ? N_DIV_W : N_DIV_D;
              end else begin
                a_r   <= {{(PW-XLEN){1'b0}}, mag1_s};
                b_r   <= mag2_s;
                cnt_r <= word ? N_MUL_W : N_MUL_D;
              end
            end
          end
        end
        S_CALC: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_r     <= S_DONE;
            out_valid_r <= 1'b1;
            result_r    <= final_s;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
            if (op_r[2]) begin
              acc_r <= {{(PW-XLEN-1){1'b0}}, rem_s};
              b_r   <= {b_r[XLEN-2:0], qbit_s};
            end else begin
              acc_r <= acc_r + pp_s;
              a_r   <= a_r << MUL_BPC;
              b_r   <= b_r >> MUL_BPC;
            end
          end
        end
        S_DONE: begin
          // Special cases arrive here with out_valid low and present next cycle
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            result_r    <= final_s;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_mdu.sv
module tb_ysyx_22050133_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        word;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_22050133_mdu #(.XLEN(64), .MUL_BPC(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .word(word), .src1(src1), .src2(src2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model: RISC-V M semantics with plain arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sp;
    logic [127:0]        up;
    int                  a32, b32, r32;
    longint              sa, sb;
    logic [31:0]         ua32, ub32;
    if (w) begin
      a32 = a[31:0]; b32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
      case (o)
        3'd0: return sx(ua32 * ub32);
        3'd4: begin
          if (b32 == 0) return {64{1'b1}};
          if (a32 == 32'sh8000_0000 && b32 == -1) return sx(a[31:0]);
          r32 = a32 / b32; return sx(r32);
        end
        3'd5: return (ub32 == 0) ? {64{1'b1}} : sx(ua32 / ub32);
        3'd6: begin
          if (b32 == 0) return sx(a[31:0]);
          if (a32 == 32'sh8000_0000 && b32 == -1) return 64'd0;
          r32 = a32 % b32; return sx(r32);
        end
        3'd7: return (ub32 == 0) ? sx(ua32) : sx(ua32 % ub32);
        default: return 64'd0;
      endcase
    end else begin
      sa = a; sb = b;
      case (o)
        3'd0: return a * b;
        3'd1: begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return sp[127:64]; end
        3'd2: begin sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); return sp[127:64]; end
        3'd3: begin up = {64'd0, a} * {64'd0, b}; return up[127:64]; end
        3'd4: begin
          if (b == 64'd0) return {64{1'b1}};
          if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return a;
          return sa / sb;
        end
        3'd5: return (b == 64'd0) ? {64{1'b1}} : a / b;
        3'd6: begin
          if (b == 64'd0) return a;
          if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return 64'd0;
          return sa % sb;
        end
        3'd7: return (b == 64'd0) ? a : a % b;
        default: return 64'd0;
      endcase
    end
  endfunction

  // Expected edges from accept to out_valid rising
  function automatic int ref_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    if (w && o >= 3'd1 && o <= 3'd3) return 1;
    if (o >= 3'd4) begin
      if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
      if ((o == 3'd4 || o == 3'd6) &&
          (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
             : (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}))) return 1;
    end
    return w ? 33 : 65;
  endfunction

  task automatic issue(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    chk({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    op = o; word = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); word = 1'($urandom);
    src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int lat;
    issue(tag, o, w, a, b);
    wait_valid(lat);
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".res"}, result, exp_res);
    handshake();
    chk({tag, ".drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return {64{1'b1}};
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 100));
      5: return sx($urandom);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int          lat;
    bit          seen;
    logic [2:0]  ro;
    logic        rw;
    logic [63:0] ra, rb;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = 3'd0; word = 1'b0;
    src1 = 64'd0; src2 = 64'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.result", result, 64'd0);
    rst = 1'b0;

    // Directed cases
    run_op("mul_3_m5", 3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65);
    run_op("mulh",     3'd1, 1'b0, {64{1'b1}}, 64'd2, {64{1'b1}}, 65);
    run_op("mulhu",    3'd3, 1'b0, {64{1'b1}}, 64'd2, 64'd1, 65);
    run_op("mulhsu",   3'd2, 1'b0, {64{1'b1}}, 64'd2, {64{1'b1}}, 65);
    run_op("div_by0",  3'd4, 1'b0, 64'd7, 64'd0, {64{1'b1}}, 1);
    run_op("rem_by0",  3'd6, 1'b0, 64'd7, 64'd0, 64'd7, 1);
    run_op("div_ovf",  3'd4, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf",  3'd6, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'd0, 1);
    run_op("divw",     3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("remw",     3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, {64{1'b1}}, 33);
    run_op("divuw",    3'd5, 1'b1, 64'h1_0000_0008, 64'd2, 64'd4, 33);
    run_op("mulhw_illegal", 3'd1, 1'b1, 64'd5, 64'd9, 64'd0, 1);
    run_op("mulw",     3'd0, 1'b1, 64'h1234_0000_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 33);

    // Back-pressure in DONE: result held, new request not accepted early
    issue("hold", 3'd0, 1'b0, 64'd6, 64'd7);
    wait_valid(lat);
    chk("hold.lat", 64'(lat), 64'd65);
    op = 3'd5; word = 1'b0; src1 = 64'd1000; src2 = 64'd10; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold.result", result, 64'd42);
      chk("hold.in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hold.idle_busy", {63'd0, busy}, 64'd0);
    chk("hold.idle_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hold.accept_busy", {63'd0, busy}, 64'd1);
    wait_valid(lat);
    chk("hold.next_lat", 64'(lat), 64'd65);
    chk("hold.next_res", result, 64'd100);
    handshake();

    // Flush during a DIVU
    issue("flush_div", 3'd5, 1'b0, 64'd12345, 64'd11);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush.out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush.in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush.busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
    chk("flush.no_result", {63'd0, seen}, 64'd0);
    run_op("divu_100_7", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);

    // Flush beats out_ready in DONE
    issue("flush_done", 3'd0, 1'b0, 64'd5, 64'd5);
    wait_valid(lat);
    chk("flush_done.res", result, 64'd25);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done.out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_done.result_kept", result, 64'd25);
    chk("flush_done.busy", {63'd0, busy}, 64'd0);

    // Reset in the middle of a MUL
    issue("rst_mul", 3'd0, 1'b0, 64'd123, 64'd456);
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mul.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_mul.result", result, 64'd0);
    chk("rst_mul.busy", {63'd0, busy}, 64'd0);
    chk("rst_mul.in_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
    chk("rst_mul.no_result", {63'd0, seen}, 64'd0);

    // Randomised operations against the reference model
    for (int k = 0; k < 40; k++) begin
      ro = 3'($urandom);
      rw = 1'($urandom);
      ra = rnd_operand();
      rb = rnd_operand();
      run_op($sformatf("rnd%0d_op%0d_w%0d", k, ro, rw), ro, rw, ra, rb,
             ref_model(ro, rw, ra, rb), ref_lat(ro, rw, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
